// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and the GF(2^8) round helpers.
package aes_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned SCHED_W = BLOCK_W * (NR + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word is row 0 in the top byte down to row 3 in the bottom byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[x];

endmodule

// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock over a pre-expanded key schedule,
// valid/ready handshake on both sides.
module aes128_cipher_iter #(
  parameter int unsigned NR      = 10,
  parameter int unsigned SCHED_W = 128 * (NR + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [aes_pkg::BLOCK_W-1:0] plaintext,
  input  logic [SCHED_W-1:0]          key_sched,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [aes_pkg::BLOCK_W-1:0] ciphertext
);
  import aes_pkg::*;

  if (NR != aes_pkg::NR || SCHED_W != aes_pkg::SCHED_W) begin : g_cfg_check
    $fatal(1, "aes128_cipher_iter: only NR=10 with SCHED_W=1408 is supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  state_t               state_q, state_d;
  logic [3:0]           round_q;
  logic [SCHED_W-1:0]   sched_q;
  logic [BLOCK_W-1:0]   st_q, ct_q;
  logic [BLOCK_W-1:0]   sb, sr, mc, rk, rnd_out;
  logic                 last_round;

  assign last_round = (round_q == LAST);

  // SubBytes: 16 parallel S-box lookups
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x (st_q[8*i +: 8]),
      .y (sb[8*i +: 8])
    );
  end

  assign sr = shift_rows(sb);

  always_comb begin
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127 - 32 * c -: 32] = mix_column(sr[127 - 32 * c -: 32]);
    end
  end

  // Round-key select; out-of-range counter values yield zero
  always_comb begin
    rk = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (round_q == 4'(i)) rk = sched_q[SCHED_W - 1 - 128 * i -: 128];
    end
  end

  assign rnd_out = (last_round ? sr : mc) ^ rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: begin
        if (last_round)                           state_d = DONE;
        else if (round_q == '0 || round_q > LAST) state_d = IDLE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result is copied into its own register so ciphertext holds across the next job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      sched_q <= '0;
      st_q    <= '0;
      ct_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sched_q <= key_sched;
            st_q    <= plaintext ^ key_sched[SCHED_W-1 -: BLOCK_W];
            round_q <= 4'd1;
          end
        end
        BUSY: begin
          st_q    <= rnd_out;
          round_q <= (state_d == BUSY) ? round_q + 4'd1 : '0;
          if (last_round) ct_q <= rnd_out;
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Self-checking bench for aes128_cipher_iter against a byte-level AES reference model.
module tb_aes128_cipher_iter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    plaintext;
  logic [1407:0]   key_sched;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    ciphertext;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_t [256];

  aes128_cipher_iter #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_sched  (key_sched),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] x, y, inv;
    for (int i = 0; i < 256; i++) begin
      x   = i[7:0];
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = j[7:0];
        if (gmul(x, y) == 8'h01) inv = y;
      end
      sb_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    s = '0;
    for (int i = 0; i < 44; i++) s[1407 - 32 * i -: 32] = w[i];
    return s;
  endfunction

  function automatic logic [127:0] model_enc(input logic [1407:0] sch, input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk, res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127 - 8 * (4 * c + r) -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r][c] = sb_t[s[r][(c + r) % 4]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            if (rnd < 10)
              s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
            else
              s[r][c] = t[r][c];
      end
      rk = sch[1407 - 128 * rnd -: 128];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[127 - 8 * (4 * c + r) -: 8];
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Present a job and return just after its acceptance edge.
  task automatic start_job(input string tag, input logic [127:0] pt, input logic [1407:0] ks);
    int n;
    plaintext = pt;
    key_sched = ks;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, {127'd0, in_ready}, 128'd1);
    tick();
  endtask

  task automatic wait_done(input string tag, input logic [127:0] exp);
    int   n;
    logic rdy_seen;
    n        = 0;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd10);
    check({tag, "_busy_rdy"}, {127'd0, rdy_seen}, 128'd0);
    check({tag, "_ct"}, ciphertext, exp);
  endtask

  task automatic run_job(input string tag, input logic [127:0] pt, input logic [1407:0] ks,
                         input logic [127:0] exp, input int bp);
    out_ready = (bp == 0);
    start_job(tag, pt, ks);
    in_valid = 1'b0;
    wait_done(tag, exp);
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_hold_ct"}, ciphertext, exp);
      check({tag, "_hold_vr"}, {126'd0, out_valid, in_ready}, 128'b10);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_after_vr"}, {126'd0, out_valid, in_ready}, 128'b01);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [1407:0] sch_b, sch_c, sch_r;
    logic [127:0]  key_r, pt_r;
    int            acc [$];
    logic [127:0]  ctq [$];
    bit            acc_now;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key_sched = '0;
    build_sbox();
    sch_b = model_expand(KEY_B);
    sch_c = model_expand(KEY_C);

    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {127'd0, in_ready}, 128'd1);
    tick();

    run_job("appb", PT_B, sch_b, CT_B, 0);
    run_job("appc", PT_C, sch_c, CT_C, 0);
    run_job("bp", PT_C, sch_c, CT_C, 20);

    // Input isolation: inputs flip to all-ones with in_valid held during BUSY/DONE
    out_ready = 1'b1;
    start_job("iso", PT_B, sch_b);
    plaintext = '1;
    key_sched = '1;
    wait_done("iso", CT_B);
    tick();
    check("iso_idle_rdy", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    wait_done("iso2", model_enc('1, '1));
    tick();

    // Reset mid-job
    start_job("rmid", PT_B, sch_b);
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rmid_vr", {126'd0, out_valid, in_ready}, 128'd0);
    check("rmid_ct", ciphertext, 128'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rmid_rel_vr", {126'd0, out_valid, in_ready}, 128'b01);
    tick();
    run_job("rmid_c", PT_C, sch_c, CT_C, 0);

    // Back-to-back with in_valid held and out_ready tied high
    out_ready = 1'b1;
    plaintext = PT_B;
    key_sched = sch_b;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc_now = in_valid && in_ready;
      if (acc_now) acc.push_back(cyc);
      if (out_valid && out_ready) ctq.push_back(ciphertext);
      tick();
      if (acc_now && acc.size() == 1) begin
        plaintext = PT_C;
        key_sched = sch_c;
      end else if (acc_now) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_nacc", 128'(acc.size()), 128'd2);
    if (acc.size() >= 2) check("b2b_gap", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b_nct", 128'(ctq.size()), 128'd2);
    if (ctq.size() >= 1) check("b2b_ct0", ctq[0], CT_B);
    if (ctq.size() >= 2) check("b2b_ct1", ctq[1], CT_C);

    // Randomized keys, blocks and backpressure
    for (int k = 0; k < 8; k++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      sch_r = model_expand(key_r);
      run_job("rand", pt_r, sch_r, model_enc(sch_r, pt_r), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_cipher_iter.md
Name: aes128_cipher_iter

Overview:
- Iterative AES-128 encryption datapath sitting directly downstream of the combinational key-expansion stage. It consumes the expanded 1408-bit round-key schedule plus one 128-bit plaintext block and produces the ciphertext.
- Executes one full round per clock. A valid/ready handshake is used on both input and output.
- Output feeds the system's ciphertext sink.

Parameters:
- NR, 10, number of rounds; only the value 10 is legal, and elaboration fails otherwise.
- SCHED_W, 128*(NR+1) = 1408, width of the round-key schedule input; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext and schedule presented
- in_ready  output  1  block can accept a new job
- plaintext  input  128  state bytes, FIPS-197 column-major, byte s0,0 = [127:120], s1,0 = [119:112], ..., s3,3 = [7:0]
- key_sched  input  SCHED_W  round key r = key_sched[SCHED_W-1-128r -: 128]; round key 0 = cipher key = bits [1407:1280]
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  same byte order as plaintext

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; round counter = 0.
  - out_valid = 0, in_ready = 0 while rst_n is low, ciphertext = 0.
  - Internal state register = 0; latched schedule = 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (edge T): latch key_sched into an internal schedule register. state <= plaintext ^ rk0; round <= 1; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge computes one round with round key rk[round]: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]).
  - When round == NR, MixColumns is bypassed.
  - round increments each edge. After the edge where round == NR is processed (edge T+10), go to DONE.
- DONE:
  - out_valid = 1; ciphertext = state, held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - No new job is accepted in the same cycle; in_ready rises on the following cycle.
- Latency: acceptance edge T → out_valid high after edge T+10. Minimum job-to-job spacing is 12 cycles when out_ready is held 1.
- Inputs plaintext/key_sched are sampled only at acceptance; changes during BUSY/DONE have no effect.
- in_valid during BUSY/DONE is ignored; the upstream must hold it until in_ready.
- ciphertext between jobs keeps the last result; it is only meaningful when out_valid = 1.
- Round arithmetic:
  - MixColumns in GF(2^8) mod x^8+x^4+x^3+x+1, with xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
  - ShiftRows rotates row r left by r columns.
- Reset asserted mid-operation aborts the job immediately. No partial output appears after release; the first cycle after release shows in_ready = 1.
- Round counter is 4 bits; values 11..15 are unreachable. A defensive default returns the FSM to IDLE.

Decomposition:
- Package aes_pkg holds:
  - NR = 10, BLOCK_W = 128, SCHED_W = 1408;
  - FSM state enum {IDLE, BUSY, DONE};
  - functions xtime, mix_column (32-bit in/out), shift_rows (128-bit).
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 16 times for SubBytes.
- Round-key select is a simple indexed slice of the latched schedule, kept in the top module.

Test Plan:
- FIPS-197 App. B: key_sched expanded from 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 → ciphertext 3925841d02dc09fbdc118597196a0b32, with out_valid rising exactly 10 edges after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid → ciphertext and out_valid stay stable and in_ready stays 0.
  - Assert out_ready → one transfer; in_ready = 1 on the next cycle.
- Input isolation: change plaintext/key_sched to all-ones and pulse in_valid during BUSY → result still equals the App. B vector; the second request is not accepted until IDLE.
- Reset mid-job: drop rst_n at edge T+5 → outputs zero immediately. After release, run the App. C.1 vector → correct result with no stale out_valid.
- Back-to-back: two jobs with out_ready tied 1 and in_valid held → acceptances exactly 12 cycles apart, both ciphertexts correct.
